// File: rtl/sdram_axi_arbiter.sv
// Two-master to one-slave AXI arbiter in front of the SDRAM controller; one whole transaction per grant.
// Build option: define ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module sdram_axi_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16,
    parameter int ID_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [7:0]          m0_awlen,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [ID_W-1:0]     m0_bid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rlast,
    output logic [ID_W-1:0]     m0_rid,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rlast,
    output logic [ID_W-1:0]     m1_rid,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [ID_W-1:0]     s_awid,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W-1:0]     s_bid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [ID_W-1:0]     s_arid,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_rlast,
    input  logic [ID_W-1:0]     s_rid,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [1:0]          grant
);

    typedef enum logic [2:0] {IDLE, ARB, AR_FWD, R_FWD, AW_FWD, W_FWD, B_WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        gnt_idx;
    logic        pref, win, win_ar, req0, req1;
    logic [8:0]  beat_cnt;
    logic [7:0]  awlen_q;
    logic        err_len;
    logic        last_beat, w_hs;
    logic        awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
    logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;

`ifdef ARB_FIXED_PRIO_EN
    assign pref = 1'b0;
`else
    logic rr_ptr;
    assign pref = rr_ptr;
`endif

    assign req0   = m0_arvalid | m0_awvalid;
    assign req1   = m1_arvalid | m1_awvalid;
    assign win    = pref ? req1 : ~req0;
    assign win_ar = win ? m1_arvalid : m0_arvalid;

    // Granted-master request/handshake view
    assign m_awvalid = gnt_idx ? m1_awvalid : m0_awvalid;
    assign m_wvalid  = gnt_idx ? m1_wvalid  : m0_wvalid;
    assign m_wlast   = gnt_idx ? m1_wlast   : m0_wlast;
    assign m_bready  = gnt_idx ? m1_bready  : m0_bready;
    assign m_arvalid = gnt_idx ? m1_arvalid : m0_arvalid;
    assign m_rready  = gnt_idx ? m1_rready  : m0_rready;

    assign s_awaddr = gnt_idx ? m1_awaddr : m0_awaddr;
    assign s_awlen  = gnt_idx ? m1_awlen  : m0_awlen;
    assign s_awid   = gnt_idx ? m1_awid   : m0_awid;
    assign s_wdata  = gnt_idx ? m1_wdata  : m0_wdata;
    assign s_wstrb  = gnt_idx ? m1_wstrb  : m0_wstrb;
    assign s_wlast  = m_wlast;
    assign s_araddr = gnt_idx ? m1_araddr : m0_araddr;
    assign s_arlen  = gnt_idx ? m1_arlen  : m0_arlen;
    assign s_arid   = gnt_idx ? m1_arid   : m0_arid;

    assign last_beat = (beat_cnt == {1'b0, awlen_q});
    assign w_hs      = s_wvalid & s_wready;

    always_comb begin
        state_next = state;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        awready_s  = 1'b0;
        wready_s   = 1'b0;
        bvalid_s   = 1'b0;
        arready_s  = 1'b0;
        rvalid_s   = 1'b0;
        case (state)
            IDLE:    if (req0 | req1) state_next = ARB;
            ARB: begin
                if (!(req0 | req1)) state_next = IDLE;
                else                state_next = win_ar ? AR_FWD : AW_FWD;
            end
            AR_FWD: begin
                s_arvalid = m_arvalid;
                arready_s = s_arready;
                if (m_arvalid && s_arready) state_next = R_FWD;
            end
            R_FWD: begin
                rvalid_s = s_rvalid;
                s_rready = m_rready;
                if (s_rvalid && m_rready && s_rlast) state_next = DONE;
            end
            AW_FWD: begin
                s_awvalid = m_awvalid;
                awready_s = s_awready;
                if (m_awvalid && s_awready) state_next = W_FWD;
            end
            W_FWD: begin
                s_wvalid = m_wvalid;
                wready_s = s_wready;
                // The beat count, not wlast, decides when the burst is over
                if (w_hs && last_beat) state_next = B_WAIT;
            end
            B_WAIT: begin
                bvalid_s = s_bvalid;
                s_bready = m_bready;
                if (s_bvalid && m_bready) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign m0_awready = awready_s & ~gnt_idx;
    assign m1_awready = awready_s &  gnt_idx;
    assign m0_wready  = wready_s  & ~gnt_idx;
    assign m1_wready  = wready_s  &  gnt_idx;
    assign m0_bvalid  = bvalid_s  & ~gnt_idx;
    assign m1_bvalid  = bvalid_s  &  gnt_idx;
    assign m0_arready = arready_s & ~gnt_idx;
    assign m1_arready = arready_s &  gnt_idx;
    assign m0_rvalid  = rvalid_s  & ~gnt_idx;
    assign m1_rvalid  = rvalid_s  &  gnt_idx;

    assign m0_rdata = grant[0] ? s_rdata : '0;
    assign m0_rlast = grant[0] & s_rlast;
    assign m0_rid   = grant[0] ? s_rid   : '0;
    assign m0_bid   = grant[0] ? s_bid   : '0;
    assign m1_rdata = grant[1] ? s_rdata : '0;
    assign m1_rlast = grant[1] & s_rlast;
    assign m1_rid   = grant[1] ? s_rid   : '0;
    assign m1_bid   = grant[1] ? s_bid   : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt_idx  <= 1'b0;
            grant    <= 2'b00;
            beat_cnt <= '0;
            awlen_q  <= '0;
            err_len  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                ARB: begin
                    gnt_idx  <= win;
                    grant    <= {win, ~win};
                    beat_cnt <= '0;
                end
                AW_FWD: if (m_awvalid && s_awready) awlen_q <= (gnt_idx ? m1_awlen : m0_awlen);
                W_FWD: if (w_hs) begin
                    beat_cnt <= beat_cnt + 9'd1;
                    err_len  <= err_len | (m_wlast != last_beat);
                end
                DONE: begin
                    grant  <= 2'b00;
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr <= ~gnt_idx;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// Scoreboard bench for sdram_axi_arbiter: directed transactions, slave model, per-channel expected queues.
module tb_sdram_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] m_awaddr[2];
    logic [7:0]  m_awlen[2];
    logic [7:0]  m_awid[2];
    logic [1:0]  m_awvalid, m_awready;
    logic [15:0] m_wdata[2];
    logic [1:0]  m_wstrb[2];
    logic [1:0]  m_wlast, m_wvalid, m_wready;
    logic [1:0]  m_bvalid, m_bready;
    logic [7:0]  m_bid[2];
    logic [21:0] m_araddr[2];
    logic [7:0]  m_arlen[2];
    logic [7:0]  m_arid[2];
    logic [1:0]  m_arvalid, m_arready;
    logic [15:0] m_rdata[2];
    logic [1:0]  m_rlast, m_rvalid, m_rready;
    logic [7:0]  m_rid[2];

    logic [21:0] s_awaddr, s_araddr;
    logic [7:0]  s_awlen, s_awid, s_arlen, s_arid, s_bid, s_rid;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [15:0] s_wdata, s_rdata;
    logic [1:0]  s_wstrb, grant;

    sdram_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awid(m_awid[0]),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
        .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
        .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bid(m_bid[0]),
        .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arid(m_arid[0]),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rlast(m_rlast[0]), .m0_rid(m_rid[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awid(m_awid[1]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
        .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
        .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bid(m_bid[1]),
        .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arid(m_arid[1]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rlast(m_rlast[1]), .m1_rid(m_rid[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awid(s_awid),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0] q_ar[$], q_aw[$], q_w[$], q_r0[$], q_r1[$], q_b0[$], q_b1[$];
    logic [1:0]  q_g[$];
    logic [1:0]  prev_grant = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Expected traffic for one read: slave-side AR plus master-side R beats
    task automatic push_rd(input int idx, input logic [21:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input logic [15:0] rbase);
        logic [15:0] d;
        q_ar.push_back({26'd0, addr, len, id});
        for (int i = 0; i <= int'(len); i++) begin
            d = rbase + i[15:0];
            if (idx == 0) q_r0.push_back({39'd0, d, (i == int'(len)), id});
            else          q_r1.push_back({39'd0, d, (i == int'(len)), id});
        end
    endtask

    task automatic push_wr(input int idx, input logic [21:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input logic [15:0] wbase, input int last_at);
        logic [15:0] d;
        q_aw.push_back({26'd0, addr, len, id});
        for (int i = 0; i <= int'(len); i++) begin
            d = wbase + i[15:0];
            q_w.push_back({45'd0, 2'b11, d, (i == last_at)});
        end
        if (idx == 0) q_b0.push_back({56'd0, id});
        else          q_b1.push_back({56'd0, id});
    endtask

    task automatic do_read(input int idx, input logic [21:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input bit lat);
        bit ok;
        @(posedge clk); #1;
        m_araddr[idx] = addr; m_arlen[idx] = len; m_arid[idx] = id; m_arvalid[idx] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (lat && c <= 2) check("ar_latency", {63'd0, s_arvalid}, {63'd0, (c == 2)});
            if (m_arready[idx]) ok = 1'b1;
        end
        if (!ok) check("ar_timeout", 0, 1);
        @(posedge clk); #1;
        m_arvalid[idx] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = (idx == 0) ? (q_r0.size() == 0) : (q_r1.size() == 0);
        end
        if (!ok) check("r_timeout", 0, 1);
    endtask

    task automatic do_write(input int idx, input logic [21:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input logic [15:0] wbase, input int last_at);
        bit ok;
        @(posedge clk); #1;
        m_awaddr[idx] = addr; m_awlen[idx] = len; m_awid[idx] = id; m_awvalid[idx] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (m_awready[idx]) ok = 1'b1;
        end
        if (!ok) check("aw_timeout", 0, 1);
        @(posedge clk); #1;
        m_awvalid[idx] = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            m_wdata[idx] = wbase + i[15:0]; m_wstrb[idx] = 2'b11;
            m_wlast[idx] = (i == last_at); m_wvalid[idx] = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 3000 && !ok; c++) begin
                @(negedge clk);
                if (m_wready[idx]) ok = 1'b1;
            end
            if (!ok) check("w_timeout", 0, 1);
            @(posedge clk); #1;
        end
        m_wvalid[idx] = 1'b0; m_wlast[idx] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = (idx == 0) ? (q_b0.size() == 0) : (q_b1.size() == 0);
        end
        if (!ok) check("b_timeout", 0, 1);
    endtask

    // Slave model: always ready on AR/AW/W; read data = (araddr[15:0] ^ 0x01A0) + beat
    initial begin
        bit hs_ar, hs_aw, hs_w, hs_r, hs_b, rd_act, b_pend;
        logic [21:0] rd_addr, c_addr;
        logic [7:0]  rd_len, rd_id, wr_len, wr_id, c_len, c_id, c_wlen, c_wid;
        int rd_beat, wr_cnt;
        rd_act = 0; b_pend = 0; rd_beat = 0; wr_cnt = 0;
        rd_addr = '0; rd_len = '0; rd_id = '0; wr_len = '0; wr_id = '0;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0; s_rid = '0;
        s_bvalid = 1'b0; s_bid = '0;
        forever begin
            @(negedge clk);
            hs_ar = reset && s_arvalid && s_arready;
            hs_aw = reset && s_awvalid && s_awready;
            hs_w  = reset && s_wvalid && s_wready;
            hs_r  = reset && s_rvalid && s_rready;
            hs_b  = reset && s_bvalid && s_bready;
            c_addr = s_araddr; c_len = s_arlen; c_id = s_arid;
            c_wlen = s_awlen; c_wid = s_awid;
            @(posedge clk); #1;
            if (!reset) begin
                rd_act = 0; b_pend = 0; rd_beat = 0; wr_cnt = 0;
            end else begin
                if (hs_r) begin
                    if (rd_beat == int'(rd_len)) rd_act = 0;
                    else rd_beat++;
                end
                if (hs_ar) begin rd_act = 1; rd_beat = 0; rd_addr = c_addr; rd_len = c_len; rd_id = c_id; end
                if (hs_aw) begin wr_len = c_wlen; wr_id = c_wid; wr_cnt = 0; end
                if (hs_w) begin
                    if (wr_cnt == int'(wr_len)) b_pend = 1;
                    wr_cnt++;
                end
                if (hs_b) b_pend = 0;
            end
            s_rvalid = rd_act;
            s_rdata  = (rd_addr[15:0] ^ 16'h01A0) + rd_beat[15:0];
            s_rlast  = (rd_beat == int'(rd_len));
            s_rid    = rd_id;
            s_bvalid = b_pend;
            s_bid    = wr_id;
        end
    end

    // Monitor: pops the matching expectation whenever the DUT presents a transfer
    always @(negedge clk) begin
        if (reset) begin
            if (s_arvalid && s_arready) begin
                if (q_ar.size() == 0) check("ar_extra", 1, 0);
                else check("s_ar", {26'd0, s_araddr, s_arlen, s_arid}, q_ar.pop_front());
            end
            if (s_awvalid && s_awready) begin
                if (q_aw.size() == 0) check("aw_extra", 1, 0);
                else check("s_aw", {26'd0, s_awaddr, s_awlen, s_awid}, q_aw.pop_front());
            end
            if (s_wvalid && s_wready) begin
                if (q_w.size() == 0) check("w_extra", 1, 0);
                else check("s_w", {45'd0, s_wstrb, s_wdata, s_wlast}, q_w.pop_front());
            end
            if (m_rvalid[0] && m_rready[0]) begin
                if (q_r0.size() == 0) check("r0_extra", 1, 0);
                else check("m0_r", {39'd0, m_rdata[0], m_rlast[0], m_rid[0]}, q_r0.pop_front());
            end
            if (m_rvalid[1] && m_rready[1]) begin
                if (q_r1.size() == 0) check("r1_extra", 1, 0);
                else check("m1_r", {39'd0, m_rdata[1], m_rlast[1], m_rid[1]}, q_r1.pop_front());
            end
            if (m_bvalid[0] && m_bready[0]) begin
                if (q_b0.size() == 0) check("b0_extra", 1, 0);
                else check("m0_b", {56'd0, m_bid[0]}, q_b0.pop_front());
            end
            if (m_bvalid[1] && m_bready[1]) begin
                if (q_b1.size() == 0) check("b1_extra", 1, 0);
                else check("m1_b", {56'd0, m_bid[1]}, q_b1.pop_front());
            end
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                if (q_g.size() == 0) check("grant_extra", {62'd0, grant}, 0);
                else check("grant_order", {62'd0, grant}, {62'd0, q_g.pop_front()});
            end
        end
        if (grant == 2'b00)
            check("idle_quiet", {49'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                                 s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 0);
        else if (grant == 2'b01)
            check("m1_quiet", {59'd0, m_awready[1], m_wready[1], m_bvalid[1], m_arready[1], m_rvalid[1]}, 0);
        else if (grant == 2'b10)
            check("m0_quiet", {59'd0, m_awready[0], m_wready[0], m_bvalid[0], m_arready[0], m_rvalid[0]}, 0);
        else
            check("grant_onehot", {62'd0, grant}, 1);
        prev_grant = grant;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = '0; m_awlen[i] = '0; m_awid[i] = '0;
            m_wdata[i] = '0; m_wstrb[i] = '0;
            m_araddr[i] = '0; m_arlen[i] = '0; m_arid[i] = '0;
        end
        m_awvalid = '0; m_wlast = '0; m_wvalid = '0; m_arvalid = '0;
        m_bready = 2'b11; m_rready = 2'b11;

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", {62'd0, grant}, 0);
        check("rst_outputs", {49'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                              s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 0);
        reset = 1'b1;

        // Single read on m0, latency and grant release
        q_g.push_back(2'b01);
        push_rd(0, 22'h000100, 8'd3, 8'h01, 16'h00A0);
        do_read(0, 22'h000100, 8'd3, 8'h01, 1'b1);
        @(negedge clk); @(negedge clk);
        check("grant_released", {62'd0, grant}, 0);

        // 256-beat write on m1
        q_g.push_back(2'b10);
        push_wr(1, 22'h3FFF00, 8'd255, 8'h5A, 16'h0000, 255);
        do_write(1, 22'h3FFF00, 8'd255, 8'h5A, 16'h0000, 255);

        // Contention with pointer at m0: m0 then m1
        q_g.push_back(2'b01); q_g.push_back(2'b10);
        push_rd(0, 22'h000200, 8'd1, 8'h02, 16'h03A0);
        push_rd(1, 22'h000400, 8'd2, 8'h81, 16'h05A0);
        fork
            do_read(0, 22'h000200, 8'd1, 8'h02, 1'b0);
            do_read(1, 22'h000400, 8'd2, 8'h81, 1'b0);
        join

        // m0 alone moves the pointer to m1; contention now serves m1 then m0
        q_g.push_back(2'b01);
        push_rd(0, 22'h000600, 8'd0, 8'h03, 16'h07A0);
        do_read(0, 22'h000600, 8'd0, 8'h03, 1'b0);
        q_g.push_back(2'b10); q_g.push_back(2'b01);
        push_rd(1, 22'h000A00, 8'd0, 8'h82, 16'h0BA0);
        push_rd(0, 22'h000800, 8'd1, 8'h04, 16'h09A0);
        fork
            do_read(0, 22'h000800, 8'd1, 8'h04, 1'b0);
            do_read(1, 22'h000A00, 8'd0, 8'h82, 1'b0);
        join

        // Read-over-write inside m0
        q_g.push_back(2'b01); q_g.push_back(2'b01);
        push_rd(0, 22'h000C00, 8'd1, 8'h05, 16'h0DA0);
        push_wr(0, 22'h001000, 8'd1, 8'h06, 16'h1000, 1);
        fork
            do_read(0, 22'h000C00, 8'd1, 8'h05, 1'b0);
            do_write(0, 22'h001000, 8'd1, 8'h06, 16'h1000, 1);
            begin
                ok = 1'b0;
                for (int c = 0; c < 3000 && !ok; c++) begin
                    @(negedge clk);
                    if (s_awvalid) ok = 1'b1;
                end
                check("read_before_write", {32'd0, ok, 31'd0} | q_r0.size(), {32'd0, 1'b1, 31'd0});
            end
        join

        // All four requests at once, pointer at m1
        q_g.push_back(2'b10); q_g.push_back(2'b01); q_g.push_back(2'b10); q_g.push_back(2'b01);
        push_rd(1, 22'h000E00, 8'd0, 8'h83, 16'h0FA0);
        push_rd(0, 22'h001200, 8'd1, 8'h07, 16'h13A0);
        push_wr(1, 22'h002000, 8'd2, 8'h84, 16'h2000, 2);
        push_wr(0, 22'h003000, 8'd1, 8'h08, 16'h3000, 1);
        fork
            do_read(0, 22'h001200, 8'd1, 8'h07, 1'b0);
            do_read(1, 22'h000E00, 8'd0, 8'h83, 1'b0);
            do_write(0, 22'h003000, 8'd1, 8'h08, 16'h3000, 1);
            do_write(1, 22'h002000, 8'd2, 8'h84, 16'h2000, 2);
        join

        // Early wlast: forwarded as received, burst still ends on the count
        q_g.push_back(2'b01);
        push_wr(0, 22'h004000, 8'd1, 8'h09, 16'h4000, 0);
        do_write(0, 22'h004000, 8'd1, 8'h09, 16'h4000, 0);

        // Reset while beat 2 of 8 is on the bus
        q_g.push_back(2'b01);
        q_aw.push_back({26'd0, 22'h005000, 8'd7, 8'h0A});
        q_w.push_back({45'd0, 2'b11, 16'h5000, 1'b0});
        @(posedge clk); #1;
        m_awaddr[0] = 22'h005000; m_awlen[0] = 8'd7; m_awid[0] = 8'h0A; m_awvalid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (m_awready[0]) ok = 1'b1;
        end
        if (!ok) check("rst_aw_timeout", 0, 1);
        @(posedge clk); #1;
        m_awvalid[0] = 1'b0;
        m_wdata[0] = 16'h5000; m_wstrb[0] = 2'b11; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (m_wready[0]) ok = 1'b1;
        end
        if (!ok) check("rst_w_timeout", 0, 1);
        @(posedge clk); #1;
        m_wdata[0] = 16'h5001;
        #1 check("pre_reset_wready", {63'd0, m_wready[0]}, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_grant", {62'd0, grant}, 0);
        check("midrst_outputs", {49'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                                 s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 0);
        m_wvalid[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Normal arbitration after reset release
        q_g.push_back(2'b10);
        push_rd(1, 22'h001400, 8'd1, 8'h85, 16'h15A0);
        do_read(1, 22'h001400, 8'd1, 8'h85, 1'b0);

        repeat (4) @(negedge clk);
        check("queues_drained", q_ar.size() + q_aw.size() + q_w.size() + q_r0.size() + q_r1.size()
                                + q_b0.size() + q_b1.size() + q_g.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
